// File: rtl/alu_serial_slice_if.sv
// Operand/result bus of alu_serial_slice: request side (in_*) and result side (out_*).
// Parity exists only when ALU_PARITY_EN is defined.
//
// Handshake: a transfer happens on a rising edge where valid && ready; the
// producer holds valid and its data stable until that edge, and ready never
// depends combinationally on valid.
interface alu_serial_slice_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             AInvert;
  logic             BInvert;
  logic             CarryIn;
  logic [1:0]       Operation;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Result;
  logic             CarryOut;
  logic             Zero;
  logic             Overflow;
`ifdef ALU_PARITY_EN
  logic             Parity;

  modport master (
    output in_valid, A, B, AInvert, BInvert, CarryIn, Operation, out_ready,
    input  in_ready, out_valid, Result, CarryOut, Zero, Overflow, Parity
  );
  modport slave (
    input  in_valid, A, B, AInvert, BInvert, CarryIn, Operation, out_ready,
    output in_ready, out_valid, Result, CarryOut, Zero, Overflow, Parity
  );
`else
  modport master (
    output in_valid, A, B, AInvert, BInvert, CarryIn, Operation, out_ready,
    input  in_ready, out_valid, Result, CarryOut, Zero, Overflow
  );
  modport slave (
    input  in_valid, A, B, AInvert, BInvert, CarryIn, Operation, out_ready,
    output in_ready, out_valid, Result, CarryOut, Zero, Overflow
  );
`endif
endinterface

// File: rtl/alu_serial_slice.sv
// Digit-serial ALU (AND/OR/ADD/SLT) processing DIGIT bits per cycle through a carry flop.
// Optional even-parity output enabled by defining ALU_PARITY_EN.
module alu_serial_slice #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_serial_slice_if.slave   bus,
  output logic [1:0]          dbg_state
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH % DIGIT) != 0 || WIDTH < 2 || DIGIT < 1) begin : g_bad_params
    $error("alu_serial_slice: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] aop, bop, acc;
  logic [1:0]       op;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             last;
  logic [DIGIT-1:0] a_d, b_d, sum_d, digit_res;
  logic [DIGIT:0]   sum;
  logic             dig_co, c_msb, add_ovf;
  logic [WIDTH-1:0] full, final_res;
  logic             final_co, final_ovf;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)          state_nxt = RUN;
      RUN:     if (last)                  state_nxt = DONE;
      DONE:    if (bus.out_ready)         state_nxt = IDLE;
      default:                            state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign dbg_state     = state;

  // Operands shift right each RUN cycle, so the active digit is always the low DIGIT bits.
  assign last  = (cnt == CW'(N - 1));
  assign a_d   = aop[DIGIT-1:0];
  assign b_d   = bop[DIGIT-1:0];
  assign sum   = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT{1'b0}}, carry};
  assign sum_d = sum[DIGIT-1:0];
  assign dig_co = sum[DIGIT];
  // Carry into the digit's top bit recovered from its sum bit: s = a ^ b ^ cin.
  assign c_msb   = a_d[DIGIT-1] ^ b_d[DIGIT-1] ^ sum_d[DIGIT-1];
  assign add_ovf = c_msb ^ dig_co;

  always_comb begin
    case (op)
      2'b00:   digit_res = a_d & b_d;
      2'b01:   digit_res = a_d | b_d;
      default: digit_res = sum_d;
    endcase
  end

  assign full = (acc >> DIGIT) | (WIDTH'(digit_res) << (WIDTH - DIGIT));

  always_comb begin
    final_res = full;
    final_co  = 1'b0;
    final_ovf = 1'b0;
    case (op)
      2'b10: begin
        final_co  = dig_co;
        final_ovf = add_ovf;
      end
      2'b11: begin
        final_res = WIDTH'(full[WIDTH-1] ^ add_ovf);
        final_co  = dig_co;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aop          <= '0;
      bop          <= '0;
      acc          <= '0;
      op           <= 2'b00;
      carry        <= 1'b0;
      cnt          <= '0;
      bus.Result   <= '0;
      bus.CarryOut <= 1'b0;
      bus.Zero     <= 1'b0;
      bus.Overflow <= 1'b0;
`ifdef ALU_PARITY_EN
      bus.Parity   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          aop   <= bus.AInvert ? ~bus.A : bus.A;
          bop   <= bus.BInvert ? ~bus.B : bus.B;
          op    <= bus.Operation;
          carry <= bus.CarryIn;
          cnt   <= '0;
          acc   <= '0;
        end
        RUN: begin
          aop <= aop >> DIGIT;
          bop <= bop >> DIGIT;
          acc <= full;
          cnt <= cnt + CW'(1);
          if (op[1]) carry <= dig_co;
          // Visible outputs only change once the whole word is known.
          if (last) begin
            bus.Result   <= final_res;
            bus.CarryOut <= final_co;
            bus.Zero     <= (final_res == '0);
            bus.Overflow <= final_ovf;
`ifdef ALU_PARITY_EN
            bus.Parity   <= ^final_res;
`endif
          end
        end
        default: ;
      endcase
    end
  end
endmodule
